// File: rtl/line_window_buffer_pkg.sv
// Shared definitions for the line window buffer: tap limits, address width helper, tap index type.
package line_window_pkg;

  localparam int unsigned MAX_TAPS = 8;

  typedef logic [$clog2(MAX_TAPS)-1:0] tap_idx_t;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/line_window_buffer_row_ram.sv
// Simple dual-port row RAM: registered read that holds when idle, independent write port.
module line_window_row_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DATA_DEPTH = 640,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_addr];
  end

  // Only the read register is cleared; array contents survive reset.
  always_ff @(posedge clock) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/line_window_buffer.sv
// Column line buffer: NUM_TAPS-1 circular row RAMs, one vertically aligned column per input pixel.
// Optional top-border replication enabled by defining LINE_WINDOW_BUFFER_REPLICATE_EN.
module line_window_buffer
  import line_window_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DATA_DEPTH = 640,
  parameter int unsigned NUM_TAPS   = 3
) (
  input  logic                             clock,
  input  logic                             rst,
  input  logic [$clog2(DATA_DEPTH+1)-1:0]  line_width,
  input  logic                             in_valid,
  input  logic                             in_sof,
  input  logic [DATA_WIDTH-1:0]            in_data,
  output logic [NUM_TAPS*DATA_WIDTH-1:0]   taps,
  output logic                             out_valid,
  output logic                             out_sol,
  output logic                             out_eol
);

  localparam int unsigned AW = addr_width(DATA_DEPTH);
  localparam int unsigned LW = $clog2(DATA_DEPTH + 1);
  localparam int unsigned NR = NUM_TAPS - 1;
  localparam logic [LW-1:0] LW_MAX = LW'(DATA_DEPTH);
  localparam logic [LW-1:0] LW_MIN = LW'(2);
  localparam tap_idx_t ROWS_FULL = tap_idx_t'(NR);

  logic [LW-1:0]         lw_q, lw_d, lw_in, cur_lw;
  logic [AW-1:0]         col_q, col_d, cur_col, wr_col_q, wr_col_d;
  tap_idx_t              rows_q, rows_d, cur_rows;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  wr_en_q, wr_en_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_sol_q, out_sol_d;
  logic                  out_eol_q, out_eol_d;
  logic                  col_last, rows_full;

  logic [DATA_WIDTH-1:0] rd_data [NR];
  logic [DATA_WIDTH-1:0] wr_data [NR];
  logic [DATA_WIDTH-1:0] tap_val [MAX_TAPS];

  always_comb begin
    lw_in = line_width;
    if (line_width < LW_MIN)      lw_in = LW_MIN;
    else if (line_width > LW_MAX) lw_in = LW_MAX;

    // An accepted in_sof restarts the frame on this very beat with the new width.
    cur_lw    = (in_sof) ? lw_in : lw_q;
    cur_col   = (in_sof) ? '0 : col_q;
    cur_rows  = (in_sof) ? '0 : rows_q;
    col_last  = (LW'(cur_col) == (cur_lw - LW'(1)));
    rows_full = (cur_rows == ROWS_FULL);

    lw_d        = lw_q;
    col_d       = col_q;
    rows_d      = rows_q;
    data_d      = data_q;
    wr_col_d    = wr_col_q;
    wr_en_d     = in_valid;
    out_valid_d = 1'b0;
    out_sol_d   = 1'b0;
    out_eol_d   = 1'b0;

    if (in_valid) begin
      lw_d     = cur_lw;
      data_d   = in_data;
      wr_col_d = cur_col;
      col_d    = col_last ? '0 : cur_col + AW'(1);
      rows_d   = (col_last && !rows_full) ? cur_rows + tap_idx_t'(1) : cur_rows;
`ifdef LINE_WINDOW_BUFFER_REPLICATE_EN
      out_valid_d = 1'b1;
      out_sol_d   = (cur_col == '0);
      out_eol_d   = col_last;
`else
      out_valid_d = rows_full;
      out_sol_d   = rows_full && (cur_col == '0);
      out_eol_d   = rows_full && col_last;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      lw_q        <= LW_MAX;
      col_q       <= '0;
      rows_q      <= '0;
      data_q      <= '0;
      wr_col_q    <= '0;
      wr_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_sol_q   <= 1'b0;
      out_eol_q   <= 1'b0;
    end else begin
      lw_q        <= lw_d;
      col_q       <= col_d;
      rows_q      <= rows_d;
      data_q      <= data_d;
      wr_col_q    <= wr_col_d;
      wr_en_q     <= wr_en_d;
      out_valid_q <= out_valid_d;
      out_sol_q   <= out_sol_d;
      out_eol_q   <= out_eol_d;
    end
  end

  // Each beat's column is written back one cycle after its read, shifted down one row.
  for (genvar k = 0; k < NR; k++) begin : g_row
    if (k == 0) begin : g_first
      assign wr_data[k] = data_q;
    end else begin : g_chain
      assign wr_data[k] = rd_data[k-1];
    end

    line_window_row_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .DATA_DEPTH(DATA_DEPTH),
      .ADDR_WIDTH(AW)
    ) u_ram (
      .clock   (clock),
      .rst     (rst),
      .rd_en   (in_valid),
      .rd_addr (cur_col),
      .rd_data (rd_data[k]),
      .wr_en   (wr_en_q),
      .wr_addr (wr_col_q),
      .wr_data (wr_data[k])
    );
  end

`ifdef LINE_WINDOW_BUFFER_REPLICATE_EN
  tap_idx_t rows_s_q, rows_s_d;

  always_comb begin
    rows_s_d = rows_s_q;
    if (in_valid) rows_s_d = cur_rows;
  end

  always_ff @(posedge clock) begin
    if (rst) rows_s_q <= '0;
    else     rows_s_q <= rows_s_d;
  end
`endif

  always_comb begin
    for (int unsigned k = 0; k < MAX_TAPS; k++) tap_val[k] = '0;
    tap_val[0] = data_q;
    for (int unsigned k = 0; k < NR; k++) tap_val[k+1] = rd_data[k];

    taps = '0;
    for (int unsigned k = 0; k < NUM_TAPS; k++) begin
`ifdef LINE_WINDOW_BUFFER_REPLICATE_EN
      // Rows not yet filled in this frame repeat the oldest valid row.
      if (tap_idx_t'(k) > rows_s_q) taps[k*DATA_WIDTH +: DATA_WIDTH] = tap_val[rows_s_q];
      else                          taps[k*DATA_WIDTH +: DATA_WIDTH] = tap_val[k];
`else
      taps[k*DATA_WIDTH +: DATA_WIDTH] = tap_val[k];
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_sol   = out_sol_q;
  assign out_eol   = out_eol_q;

endmodule

// File: doc/line_window_buffer.md
Name: line_window_buffer

Overview:
- Parametrised successor to the fixed 3-tap column line buffer in the mdl_canny image path.
- Buffers NUM_TAPS-1 full video lines in circular row RAMs and presents one column of NUM_TAPS vertically aligned pixels per accepted input pixel.
- Line width is runtime-programmable up to DATA_DEPTH; frame start is explicit.
- Adds valid/position qualification and warm-up tracking; feeds NxN window generators (Sobel, Gaussian, NMS).

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- DATA_DEPTH, 640, maximum line width in pixels, and the depth of each row RAM.
- NUM_TAPS, 3, rows in the output column; legal range 2..8.

Ports:
- clock  in  1  sole clock; all logic on its rising edge.
- rst  in  1  synchronous active-high reset.
- line_width  in  $clog2(DATA_DEPTH+1)  pixels per line; sampled on an accepted in_sof beat.
- in_valid  in  1  pixel beat present.
- in_sof  in  1  first pixel of a frame; qualified by in_valid.
- in_data  in  DATA_WIDTH  pixel.
- taps  out  NUM_TAPS*DATA_WIDTH  slice k is the pixel k lines above the current one; slice 0 is the newest.
- out_valid  out  1  taps holds a complete column.
- out_sol  out  1  column 0 of a line.
- out_eol  out  1  last column of a line.

Behaviour:
- Accepted beat: in_valid=1. With in_valid=0 nothing advances, taps hold their value, and out_valid/out_sol/out_eol are 0.
- Latency: exactly 1 cycle from an accepted beat to its taps/out_* at the outputs. Throughput is 1 pixel per clock, with no backpressure.
- Line width register lw:
  - Resets to DATA_DEPTH.
  - Loaded from line_width on an accepted in_sof beat; that beat itself uses the new value.
  - Values below 2 clamp to 2; values above DATA_DEPTH clamp to DATA_DEPTH.
- Column counter col (0..lw-1):
  - Increments per accepted beat and wraps from lw-1 to 0.
  - in_sof forces the current beat to col=0, including mid-line; the partial line is abandoned.
- Row RAM k (k=0..NUM_TAPS-2), one shared address col:
  - Read at col in cycle t, giving registered data at t+1.
  - Write at the same col in cycle t+1, with data = the tap-k value of that beat.
  - Read returns the pixel from the same column k+1 lines earlier.
  - lw>=2 guarantees the read and write in any cycle never hit the same address.
- Output mapping: taps slice 0 = in_data registered; taps slice k+1 = RAM k read data.
- Warm-up counter rows_filled:
  - Cleared by in_sof.
  - Incremented on each accepted beat with col=lw-1.
  - Saturates at NUM_TAPS-1.
- out_valid = registered (in_valid AND rows_filled==NUM_TAPS-1), evaluated before the increment on that beat.
- out_sol / out_eol = registered col==0 / col==lw-1, gated by the out_valid condition.
- Reset: taps=0, out_valid=0, out_sol=0, out_eol=0, col=0, rows_filled=0, lw=DATA_DEPTH. RAM contents are not reset.
- Reset mid-frame discards all state. Beats before the next in_sof are processed as a frame of width DATA_DEPTH.
- Simultaneous in_sof and col==lw-1: in_sof wins; col=0 and rows_filled=0.

Optional Feature:
- Macro: LINE_WINDOW_BUFFER_REPLICATE_EN.
- Enabled (top-border replication):
  - out_valid follows in_valid from the first line of a frame.
  - Taps slices k>rows_filled output the slice rows_filled value instead of stale RAM data, using the rows_filled value sampled with that beat.
  - out_sol/out_eol are gated by in_valid only.
- Disabled: warm-up gating as in Behaviour; no substitution mux.

Decomposition:
- Shared package line_window_pkg holds:
  - MAX_TAPS=8;
  - a function computing the address width, $clog2(DATA_DEPTH);
  - a tap-index typedef.
- Sub-module line_window_row_ram: simple dual-port RAM of depth DATA_DEPTH and width DATA_WIDTH, 1-cycle registered read, independent write port. Instantiated NUM_TAPS-1 times in a generate loop.

Test Plan:
- Fill and stream: NUM_TAPS=3, line_width=4, frame of 4 lines with pixel = 16*row+col, one beat per clock. Lines 0-1 give out_valid=0. Line 2 col 1 gives taps={0x01,0x11,0x21} (slice2..0), with out_sol on col 0 and out_eol on col 3.
- Stall: same frame with in_valid toggled 1,0,1,0. Outputs are identical to gap-free streaming, with out_valid only on cycles following valid beats and taps held during gaps.
- Width change: frame A with line_width=6, then in_sof with line_width=3. rows_filled restarts, out_eol fires every 3rd beat, and the first valid column is at line 2 of frame B.
- Clamp/edge: line_width=0 behaves as 2; line_width=1000 behaves as 640; a col 639 to 0 wrap carries correct data.
- Reset mid-frame: assert rst for 1 cycle during line 3. The next cycle has out_valid=0 and taps=0, and after a new in_sof, warm-up repeats the full 2 lines.
- Replicate option (macro defined): first-line beat with value 0x05 gives out_valid=1 and taps={0x05,0x05,0x05}. A second-line beat 0x15 gives {0x05,0x05,0x15}.
